// File: rtl/panda_pcomp_pkg.sv
// Shared definitions for the panda_pcomp table sequencer:
// FSM encodings, error codes, table word indices and segment layout.
package panda_pcomp_pkg;

    localparam int LINES_DEF = 16;
    localparam int AW_DEF    = 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_ARM   = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;
    localparam logic [2:0] S_FAULT = 3'd6;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_EMPTY = 2'd1;
    localparam logic [1:0] ERR_PCOMP = 2'd2;

    localparam logic [1:0] W_START = 2'd0;
    localparam logic [1:0] W_STEP  = 2'd1;
    localparam logic [1:0] W_WIDTH = 2'd2;
    localparam logic [1:0] W_NUM   = 2'd3;

    // Word n of a line occupies bits [32n+31:32n]
    typedef struct packed {
        logic [31:0] num_dir;
        logic [31:0] width;
        logic [31:0] step;
        logic [31:0] start;
    } seg_t;

endpackage

// File: rtl/panda_pcomp_table_ram.sv
// Segment table storage: 32-bit word writes, whole-line synchronous reads.
// Contents are deliberately left uninitialised across reset.
module panda_pcomp_table_ram
    import panda_pcomp_pkg::*;
#(
    parameter int LINES = LINES_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk_i,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_line,
    input  logic [1:0]    wr_word,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_line,
    output seg_t          rd_data
);

    logic [127:0] mem [LINES];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_line][{wr_word, 5'd0} +: 32] <= wr_data;
        end
        rd_data <= mem[rd_line];
    end

endmodule

// File: rtl/panda_pcomp_table.sv
// Table-driven sequencer that plays stored compare segments into one
// panda_pcomp, re-arming it between segments and looping the table.
module panda_pcomp_table
    import panda_pcomp_pkg::*;
#(
    parameter int LINES = LINES_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          enable_i,
    input  logic [AW+1:0] TABLE_ADDR,
    input  logic [31:0]   TABLE_DATA,
    input  logic          TABLE_WSTB,
    input  logic [AW:0]   TABLE_LENGTH,
    input  logic [15:0]   REPEATS,
    input  logic          RELATIVE_IN,
    input  logic          pcomp_act_i,
    input  logic [31:0]   pcomp_err_i,
    output logic          pcomp_enable_o,
    output logic [31:0]   START_o,
    output logic [31:0]   STEP_o,
    output logic [31:0]   WIDTH_o,
    output logic [31:0]   NUM_o,
    output logic          DIR_o,
    output logic          RELATIVE_o,
    output logic          active_o,
    output logic [AW-1:0] line_o,
    output logic [15:0]   repeat_o,
    output logic [1:0]    err_o
);

    logic [2:0]    state;
    logic          enable_q;
    logic [AW:0]   len_q;
    logic [15:0]   rep_q;
    logic [AW-1:0] line;
    logic [15:0]   pass;
    seg_t          rd_data;

    logic [AW:0]   last_idx;
    logic          last_line;
    logic [15:0]   pass_nxt;
    logic          pcomp_fault;

    assign last_idx    = len_q - (AW+1)'(1);
    assign last_line   = ({1'b0, line} == last_idx);
    assign pass_nxt    = pass + 16'd1;
    assign pcomp_fault = (pcomp_err_i != '0);

    assign line_o   = line;
    assign repeat_o = pass;

    panda_pcomp_table_ram #(
        .LINES (LINES),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .wr_en   (TABLE_WSTB),
        .wr_line (TABLE_ADDR[AW+1:2]),
        .wr_word (TABLE_ADDR[1:0]),
        .wr_data (TABLE_DATA),
        .rd_line (line),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state          <= S_IDLE;
            enable_q       <= 1'b0;
            len_q          <= '0;
            rep_q          <= '0;
            line           <= '0;
            pass           <= '0;
            pcomp_enable_o <= 1'b0;
            START_o        <= '0;
            STEP_o         <= '0;
            WIDTH_o        <= '0;
            NUM_o          <= '0;
            DIR_o          <= 1'b0;
            RELATIVE_o     <= 1'b0;
            active_o       <= 1'b0;
            err_o          <= ERR_NONE;
        end else begin
            enable_q   <= enable_i;
            RELATIVE_o <= RELATIVE_IN;
            // Abort outranks every other event
            if (!enable_i) begin
                state          <= S_IDLE;
                pcomp_enable_o <= 1'b0;
                active_o       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!enable_q) begin
                            len_q <= TABLE_LENGTH;
                            rep_q <= REPEATS;
                            if (TABLE_LENGTH == '0) begin
                                err_o <= ERR_EMPTY;
                                state <= S_FAULT;
                            end else begin
                                err_o    <= ERR_NONE;
                                line     <= '0;
                                pass     <= '0;
                                active_o <= 1'b1;
                                state    <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        state <= S_LATCH;
                    end
                    S_LATCH: begin
                        START_o        <= rd_data.start;
                        STEP_o         <= rd_data.step;
                        WIDTH_o        <= rd_data.width;
                        NUM_o          <= {1'b0, rd_data.num_dir[30:0]};
                        DIR_o          <= rd_data.num_dir[31];
                        pcomp_enable_o <= 1'b1;
                        state          <= S_ARM;
                    end
                    S_ARM, S_RUN: begin
                        // An error beats a simultaneous segment completion
                        if (pcomp_fault) begin
                            err_o          <= ERR_PCOMP;
                            pcomp_enable_o <= 1'b0;
                            active_o       <= 1'b0;
                            state          <= S_FAULT;
                        end else if (state == S_ARM) begin
                            if (pcomp_act_i) begin
                                state <= S_RUN;
                            end
                        end else if (!pcomp_act_i) begin
                            pcomp_enable_o <= 1'b0;
                            state          <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        if (last_line) begin
                            line <= '0;
                            pass <= pass_nxt;
                            if (rep_q != '0 && pass_nxt == rep_q) begin
                                active_o <= 1'b0;
                                state    <= S_IDLE;
                            end else begin
                                state <= S_LOAD;
                            end
                        end else begin
                            line  <= line + AW'(1);
                            state <= S_LOAD;
                        end
                    end
                    S_FAULT: begin
                        pcomp_enable_o <= 1'b0;
                        active_o       <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_panda_pcomp_table.sv
// Scoreboard bench for panda_pcomp_table with a behavioural pcomp responder.
// Expected segments are queued by the stimulus and checked on each arm.
module tb_panda_pcomp_table;
    import panda_pcomp_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic [5:0]  TABLE_ADDR;
    logic [31:0] TABLE_DATA;
    logic        TABLE_WSTB;
    logic [4:0]  TABLE_LENGTH;
    logic [15:0] REPEATS;
    logic        RELATIVE_IN;
    logic        pcomp_act_i;
    logic [31:0] pcomp_err_i;
    logic        pcomp_enable_o;
    logic [31:0] START_o, STEP_o, WIDTH_o, NUM_o;
    logic        DIR_o, RELATIVE_o, active_o;
    logic [3:0]  line_o;
    logic [15:0] repeat_o;
    logic [1:0]  err_o;

    always #5 clk_i = ~clk_i;

    panda_pcomp_table dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .enable_i       (enable_i),
        .TABLE_ADDR     (TABLE_ADDR),
        .TABLE_DATA     (TABLE_DATA),
        .TABLE_WSTB     (TABLE_WSTB),
        .TABLE_LENGTH   (TABLE_LENGTH),
        .REPEATS        (REPEATS),
        .RELATIVE_IN    (RELATIVE_IN),
        .pcomp_act_i    (pcomp_act_i),
        .pcomp_err_i    (pcomp_err_i),
        .pcomp_enable_o (pcomp_enable_o),
        .START_o        (START_o),
        .STEP_o         (STEP_o),
        .WIDTH_o        (WIDTH_o),
        .NUM_o          (NUM_o),
        .DIR_o          (DIR_o),
        .RELATIVE_o     (RELATIVE_o),
        .active_o       (active_o),
        .line_o         (line_o),
        .repeat_o       (repeat_o),
        .err_o          (err_o)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  line;
        logic [31:0] start;
        logic [31:0] step;
        logic [31:0] width;
        logic [31:0] num;
        logic        dir;
    } exp_t;

    exp_t q[$];

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] l, input logic [31:0] st,
                        input logic [31:0] sp, input logic [31:0] w,
                        input logic [31:0] n, input logic d);
        exp_t e;
        e.line = l; e.start = st; e.step = sp;
        e.width = w; e.num = n; e.dir = d;
        q.push_back(e);
    endtask

    task automatic push_l0(); push(4'd0, 100, 10, 5, 4, 1'b0); endtask
    task automatic push_l1(); push(4'd1, 200, 20, 6, 3, 1'b1); endtask
    task automatic push_l2(); push(4'd2, 300, 30, 7, 2, 1'b0); endtask

    // pcomp model: act rises 2 cycles after arm, lasts 4 cycles
    int resp_cnt = 0;
    initial begin
        pcomp_act_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (pcomp_enable_o) begin
                resp_cnt++;
                if (resp_cnt == 2) pcomp_act_i = 1'b1;
                if (resp_cnt == 6) pcomp_act_i = 1'b0;
            end else begin
                resp_cnt = 0;
                pcomp_act_i = 1'b0;
            end
        end
    end

    // Monitor: each enable rise is one segment presented to the pcomp
    logic mon_prev = 1'b0;
    logic mon_counting = 1'b0;
    int   mon_gap = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (pcomp_enable_o && !mon_prev) begin
                if (q.size() == 0) begin
                    check("unexpected_arm", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("seg_line", 64'(line_o), 64'(e.line));
                    check("seg_start", 64'(START_o), 64'(e.start));
                    check("seg_step", 64'(STEP_o), 64'(e.step));
                    check("seg_width", 64'(WIDTH_o), 64'(e.width));
                    check("seg_num", 64'(NUM_o), 64'(e.num));
                    check("seg_dir", 64'(DIR_o), 64'(e.dir));
                end
                if (mon_counting && active_o)
                    check("gap_len", 64'(mon_gap), 64'd3);
                mon_counting = 1'b0;
            end else if (!active_o) begin
                mon_counting = 1'b0;
            end else if (mon_prev && !pcomp_enable_o) begin
                mon_counting = 1'b1;
                mon_gap = 1;
            end else if (mon_counting && !pcomp_enable_o) begin
                mon_gap++;
            end
            mon_prev = pcomp_enable_o;
        end
    end

    task automatic wr(input int l, input int w, input logic [31:0] d);
        logic [3:0] lb;
        logic [1:0] wb;
        lb = 4'(l);
        wb = 2'(w);
        @(negedge clk_i);
        TABLE_ADDR = {lb, wb};
        TABLE_DATA = d;
        TABLE_WSTB = 1'b1;
        @(negedge clk_i);
        TABLE_WSTB = 1'b0;
    endtask

    task automatic start(input int len, input int rep);
        @(negedge clk_i);
        TABLE_LENGTH = 5'(len);
        REPEATS = 16'(rep);
        enable_i = 1'b1;
    endtask

    task automatic stop();
        @(negedge clk_i);
        enable_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic wait_idle(input string name, input int max);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk_i);
            if (!active_o) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 64'(ok), 64'd1);
    endtask

    task automatic wait_run(input string name, input int l, input int r);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_i);
            if (pcomp_act_i && line_o == 4'(l) && repeat_o == 16'(r)) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 64'(ok), 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        reset_i = 1'b1;
        enable_i = 1'b0;
        TABLE_ADDR = '0;
        TABLE_DATA = '0;
        TABLE_WSTB = 1'b0;
        TABLE_LENGTH = '0;
        REPEATS = '0;
        RELATIVE_IN = 1'b0;
        pcomp_err_i = '0;
        repeat (3) @(negedge clk_i);
        check("rst_enable", 64'(pcomp_enable_o), 64'd0);
        check("rst_active", 64'(active_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_params", 64'(START_o | STEP_o | WIDTH_o | NUM_o), 64'd0);
        check("rst_misc", 64'({DIR_o, RELATIVE_o, line_o, repeat_o}), 64'd0);
        reset_i = 1'b0;

        RELATIVE_IN = 1'b1;
        @(negedge clk_i);
        check("relative", 64'(RELATIVE_o), 64'd1);

        wr(0, 0, 100); wr(0, 1, 10); wr(0, 2, 5); wr(0, 3, 32'd4);
        wr(1, 0, 200); wr(1, 1, 20); wr(1, 2, 6); wr(1, 3, 32'h8000_0003);
        wr(2, 0, 300); wr(2, 1, 30); wr(2, 2, 7); wr(2, 3, 32'd2);

        // Single segment, arm timing
        push_l0();
        start(1, 1);
        @(negedge clk_i);
        check("t1_active_c1", 64'(active_o), 64'd1);
        check("t1_en_c1", 64'(pcomp_enable_o), 64'd0);
        @(negedge clk_i);
        check("t1_en_c2", 64'(pcomp_enable_o), 64'd0);
        @(negedge clk_i);
        check("t1_en_c3", 64'(pcomp_enable_o), 64'd1);
        check("t1_start_c3", 64'(START_o), 64'd100);
        wait_idle("t1_done", 200);
        check("t1_repeat", 64'(repeat_o), 64'd1);
        check("t1_en_end", 64'(pcomp_enable_o), 64'd0);
        check("t1_err", 64'(err_o), 64'd0);
        stop();

        // Three lines, two passes
        push_l0(); push_l1(); push_l2();
        push_l0(); push_l1(); push_l2();
        start(3, 2);
        wait_idle("t2_done", 500);
        check("t2_repeat", 64'(repeat_o), 64'd2);
        check("t2_line", 64'(line_o), 64'd0);
        stop();

        // Empty table
        start(0, 1);
        @(negedge clk_i);
        check("t3_err_empty", 64'(err_o), 64'd1);
        check("t3_active", 64'(active_o), 64'd0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk_i);
            if (pcomp_enable_o) seen = 1'b1;
        end
        check("t3_no_arm", 64'(seen), 64'd0);
        stop();
        check("t3_err_kept", 64'(err_o), 64'd1);
        push_l0(); push_l1();
        start(2, 1);
        @(negedge clk_i);
        check("t3_err_clear", 64'(err_o), 64'd0);
        wait_idle("t3_done", 300);
        check("t3_repeat", 64'(repeat_o), 64'd1);
        stop();

        // pcomp error during line 1
        push_l0(); push_l1();
        start(3, 1);
        wait_run("t4_reach", 1, 0);
        @(negedge clk_i);
        pcomp_err_i = 32'd1;
        @(negedge clk_i);
        pcomp_err_i = '0;
        check("t4_err", 64'(err_o), 64'd2);
        check("t4_en", 64'(pcomp_enable_o), 64'd0);
        check("t4_active", 64'(active_o), 64'd0);
        repeat (3) @(negedge clk_i);
        check("t4_hold", 64'({err_o, pcomp_enable_o, active_o}), 64'b1000);
        stop();
        check("t4_err_kept", 64'(err_o), 64'd2);

        // Abort in pass 1, restart from line 0 pass 0
        push_l0(); push_l1(); push_l0(); push_l1();
        start(2, 0);
        wait_run("t5_reach", 1, 1);
        @(negedge clk_i);
        enable_i = 1'b0;
        @(negedge clk_i);
        check("t5_abort_en", 64'(pcomp_enable_o), 64'd0);
        check("t5_abort_act", 64'(active_o), 64'd0);
        push_l0();
        start(1, 1);
        @(negedge clk_i);
        check("t5_restart_line", 64'(line_o), 64'd0);
        check("t5_restart_pass", 64'(repeat_o), 64'd0);
        wait_idle("t5_done", 200);
        check("t5_repeat", 64'(repeat_o), 64'd1);
        stop();

        // Live rewrite of line 1 while line 0 runs
        push_l0();
        push(4'd1, 500, 20, 6, 3, 1'b1);
        start(2, 1);
        wait_run("t6_reach", 0, 0);
        wr(1, 0, 500);
        wait_idle("t6_done", 300);
        check("t6_repeat", 64'(repeat_o), 64'd1);
        stop();

        repeat (4) @(negedge clk_i);
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
